// File: rtl/cep.sv
// rtl/cep.sv - UART transmitter (8N1, optional even parity) with integrated baud generator
`timescale 1ns/1ps
module cep #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE,
  parameter int PARITY_EN   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [7:0] data_storing,
  output logic       one_by_one_bit,
  output logic       my9600clk
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(HALF - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [CW-1:0] div_cnt;
  logic          div_wrap;
  logic          tick;
  logic [2:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    data_q;

  assign div_wrap = (div_cnt == DIV_LAST);
  // tick marks the edge where the exported baud clock rises
  assign tick     = div_wrap & ~my9600clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      my9600clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      my9600clk <= ~my9600clk;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      data_q  <= 8'd0;
    end else if (tick) begin
      case (state)
        ST_IDLE, ST_STOP: begin
          if (valid_in) begin
            shift  <= data_storing;
            data_q <= data_storing;
            state  <= ST_START;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_START: begin
          bit_cnt <= 3'd0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: state <= ST_STOP;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Line is registered from the state, so it moves one clk after the tick edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      one_by_one_bit <= 1'b1;
    end else begin
      case (state)
        ST_START:  one_by_one_bit <= 1'b0;
        ST_DATA:   one_by_one_bit <= shift[0];
        ST_PARITY: one_by_one_bit <= ^data_q;
        default:   one_by_one_bit <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cep.sv
// tb/tb_cep.sv - self-checking bench for the cep UART transmitter
`timescale 1ns/1ps
module tb_cep;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [7:0] data0 = 8'd0, data1 = 8'd0;
  logic       line0, line1, mc0, mc1;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  cep #(.BAUD_DIV(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .valid_in(valid0), .data_storing(data0),
    .one_by_one_bit(line0), .my9600clk(mc0)
  );

  cep #(.BAUD_DIV(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid1), .data_storing(data1),
    .one_by_one_bit(line1), .my9600clk(mc1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_in(input logic sel, input logic v, input logic [7:0] d);
    if (sel) begin valid1 = v; data1 = d; end
    else     begin valid0 = v; data0 = d; end
  endtask

  task automatic set_valid(input logic sel, input logic v);
    if (sel) valid1 = v; else valid0 = v;
  endtask

  task automatic set_data(input logic sel, input logic [7:0] d);
    if (sel) data1 = d; else data0 = d;
  endtask

  // Returns #1 after the clk edge on which the baud clock rose
  task automatic next_tick(input logic sel);
    logic prev, cur, found;
    int   n;
    prev  = sel ? mc1 : mc0;
    found = 1'b0;
    n     = 0;
    while (!found && n < 16) begin
      @(posedge clk); #1;
      cur = sel ? mc1 : mc0;
      if (!prev && cur) found = 1'b1;
      prev = cur;
      n++;
    end
    if (!found) chk("tick_timeout", 8'd0, 8'd1);
  endtask

  task automatic sample_line(input logic sel, input string tag, input logic exp);
    @(posedge clk); #1;
    chk(tag, {7'd0, sel ? line1 : line0}, {7'd0, exp});
  endtask

  // Drives one frame and checks every bit period against the expected serial image
  task automatic run_frame(input logic sel, input logic [7:0] b, input logic keep_valid,
                           input int chg_at, input logic [7:0] chg_val);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (sel) q.push_back(^b);
    q.push_back(1'b1);
    set_in(sel, 1'b1, b);
    for (int i = 0; i < q.size(); i++) begin
      next_tick(sel);
      if (i == 0 && !keep_valid) set_valid(sel, 1'b0);
      if (i == chg_at) set_data(sel, chg_val);
      sample_line(sel, $sformatf("frame%0d_b%02h_bit%0d", sel, b, i), q[i]);
    end
  endtask

  task automatic idle_check(input logic sel, input int n);
    for (int i = 0; i < n; i++) begin
      next_tick(sel);
      sample_line(sel, $sformatf("idle%0d_%0d", sel, i), 1'b1);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       kv;

    // reset hold and baud clock phase after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line0", {7'd0, line0}, 8'd1);
    chk("rst_mc0",   {7'd0, mc0},   8'd0);
    chk("rst_line1", {7'd0, line1}, 8'd1);
    chk("rst_mc1",   {7'd0, mc1},   8'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("baud_k%0d", k), {7'd0, mc0}, 8'((k / 2) % 2));
    end

    // single frame, valid dropped after start, then idle
    run_frame(1'b0, 8'h49, 1'b0, -1, 8'h00);
    idle_check(1'b0, 2);

    // back-to-back frames with valid held
    run_frame(1'b0, 8'hA5, 1'b1, 1, 8'h3C);
    run_frame(1'b0, 8'h3C, 1'b0, -1, 8'h00);
    idle_check(1'b0, 1);

    // data change during DATA is ignored
    run_frame(1'b0, 8'h49, 1'b0, 3, 8'hFF);
    idle_check(1'b0, 1);

    // boundary bytes and random frames, some back-to-back
    run_frame(1'b0, 8'h00, 1'b0, -1, 8'h00);
    run_frame(1'b0, 8'hFF, 1'b0, -1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom);
      kv = (i < 4) ? 1'($urandom) : 1'b0;
      run_frame(1'b0, rb, kv, int'($urandom_range(1, 8)), 8'($urandom));
    end
    idle_check(1'b0, 1);

    // async reset in the middle of DATA
    set_in(1'b0, 1'b1, 8'h00);
    next_tick(1'b0);
    set_valid(1'b0, 1'b0);
    next_tick(1'b0);
    next_tick(1'b0);
    @(posedge clk); #1;
    chk("pre_reset_line", {7'd0, line0}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_rst_line", {7'd0, line0}, 8'd1);
    chk("async_rst_mc",   {7'd0, mc0},   8'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_check(1'b0, 3);
    run_frame(1'b0, 8'($urandom), 1'b0, -1, 8'h00);

    // parity-enabled instance
    run_frame(1'b1, 8'h07, 1'b0, -1, 8'h00);
    idle_check(1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      run_frame(1'b1, rb, (i < 2) ? 1'b1 : 1'b0, -1, 8'h00);
    end
    idle_check(1'b1, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
